aska_stim_sequencer: RTL
========================

Name: aska_stim_sequencer

Overview:
- Stimulation train scheduler for the ASKA neuro-stimulator digital core.
- Takes the decoded configuration fields (conf0/conf1 and the electrode1/electrode2 masks written over SPI) and sequences biphasic pulses through the envelope IDLE → RAMP_UP → ON → RAMP_DN → OFF → RAMP_UP ...
- Drives the H-bridge switch masks, the 6-bit current DAC code and pulse_active.
- Runs on the 20 kHz internal clock.

Parameters:
- CLK_PER_PERIOD_MIN, 4: floor on the effective pulse period, in clk ticks.
- AMP_FRAC, 4: fractional bits of the amplitude accumulator (ramp_factor = amplitude*16/ramp).

Ports:
- clk  in  1  20 kHz internal clock.
- reset  in  1  synchronous reset, active-high.
- enable  in  1  conf1[20]; starts or stops the stimulation train.
- freq  in  12  pulse period in clk ticks (400 = 50 Hz).
- amplitude  in  6  target DAC code (0-50 mA).
- ramp  in  6  ramp length in pulses (applies to up and down).
- ramp_factor  in  10  per-pulse amplitude step, Q6.4.
- on_time  in  8  ON plateau length in pulses.
- off_time  in  10  OFF length in periods.
- phase_dur  in  3  ticks per phase.
- electrode1  in  32  anode mask for phase A.
- electrode2  in  32  cathode mask for phase A.
- up_switches  out  32  P-switch controls.
- down_switches  out  32  N-switch controls.
- dac  out  6  DAC code.
- pulse_active  out  1  high during phase A, the gap and phase B.
- state  out  3  IDLE=0, RAMP_UP=1, ON=2, RAMP_DN=3, OFF=4.

Behaviour:
- Reset:
  - All outputs are 0; state=IDLE; accumulator acc[9:0]=0; all counters are 0.
  - Reset asserted mid-pulse forces switches to 0 on the next edge.
- Shadow config:
  - All inputs are latched into shadow registers on IDLE→RAMP_UP and on OFF→RAMP_UP.
  - Config writes made mid-train therefore take effect at the next envelope cycle.
  - enable is never shadowed.
- Effective values:
  - pd = max(phase_dur, 1).
  - per = max(freq, 2*pd+2, CLK_PER_PERIOD_MIN).
- Period counter pc counts 0..per-1 and wraps. A period starts on each cycle where pc==0.
- Pulse shape within each period (all outputs registered):
  - Phase A, for pc in [0, pd): up=electrode1, down=electrode2.
  - Gap, pc==pd: switches 0.
  - Phase B, for pc in [pd+1, 2pd]: up=electrode2, down=electrode1.
  - Rest of the period: switches 0.
  - pulse_active is high for pc in [0, 2pd].
  - dac = acc[9:4] while pulse_active is high, otherwise 0.
- Start latency: enable rises while in IDLE at edge t. state=RAMP_UP and pc=0 at edge t+1. First phase A is visible after edge t+1.
- acc update happens at each period start, before that period's pulse is emitted:
  - RAMP_UP: acc = min(acc + ramp_factor, amplitude<<4).
  - ON: acc = amplitude<<4.
  - RAMP_DN: acc = max(acc − ramp_factor, 0), using a borrow check with no wrap.
  - OFF: no pulse; switches and dac stay 0.
- Transitions happen at the last tick of the N-th period in a state, counted by the pulse counter:
  - RAMP_UP lasts ramp periods, then → ON.
  - ON lasts on_time periods, then → RAMP_DN.
  - RAMP_DN lasts ramp periods, then → OFF.
  - OFF lasts off_time periods, then → RAMP_UP with acc=0.
  - A state whose length is 0 is skipped combinationally to the following state.
  - ramp=0 means ON uses amplitude<<4 directly.
  - If all lengths are 0, the sequencer behaves as ON continuously.
- enable deasserted:
  - If a pulse is in progress, it finishes through the end of phase B (charge balance is mandatory).
  - Then → IDLE: acc=0, pc=0, outputs 0.
  - If enable falls during rest or OFF, → IDLE on the next edge.
  - Re-enable from IDLE restarts at RAMP_UP.
- Saturation: acc never exceeds amplitude<<4, even when ramp_factor*ramp overshoots.
- Electrode overlap: electrode1 & electrode2 ≠ 0 is passed through unmodified. Detecting it is the SPI-side checker's responsibility.

Test Plan:
- amplitude=50, ramp=50, ramp_factor=16, freq=400, pd=4, on=50, off=50, enable=1 → dac steps 1,2,…,50 over pulses 1–50; ON holds 50 for 50 pulses; RAMP_DN steps 49…0; OFF lasts 20000 ticks with switches 0; cycle repeats.
- Pulse shape check, same config → phase A ticks 0–3 (up=0x8000, down=0x4000), tick 4 all 0, ticks 5–8 (up=0x4000, down=0x8000), pulse_active high ticks 0–8, period 400 ticks.
- Drop enable at pc=2 of an ON pulse → phase B still completes at pc=8; state=IDLE next edge; all outputs 0.
- Mid-train write of amplitude=25, ramp=25, ramp_factor=16 during ON → the current cycle stays at 50; the next RAMP_UP ramps to 25 over 25 pulses.
- freq=3, phase_dur=0 → pd=1, per=4; pulse every 4 ticks; ramp=0 → ON immediately at full amplitude.
- Assert reset mid phase A → switches, dac and pulse_active are 0 the next edge; state=IDLE; a restart needs enable high while in IDLE.

Source files
------------

// File: rtl/aska_stim_sequencer.sv
// +--------------------------------------------------------------------------+
// | aska_stim_sequencer                                                      |
// | Biphasic stimulation train scheduler: envelope FSM, pulse shaper, DAC.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module aska_stim_sequencer #(
    parameter int CLK_PER_PERIOD_MIN = 4,
    parameter int AMP_FRAC           = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [11:0] freq,
    input  logic [5:0]  amplitude,
    input  logic [5:0]  ramp,
    input  logic [9:0]  ramp_factor,
    input  logic [7:0]  on_time,
    input  logic [9:0]  off_time,
    input  logic [2:0]  phase_dur,
    input  logic [31:0] electrode1,
    input  logic [31:0] electrode2,
    output logic [31:0] up_switches,
    output logic [31:0] down_switches,
    output logic [5:0]  dac,
    output logic        pulse_active,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RAMP_UP = 3'd1,
        ON      = 3'd2,
        RAMP_DN = 3'd3,
        OFF     = 3'd4
    } state_t;

    function automatic logic [2:0] eff_pd(input logic [2:0] d);
        return (d == 3'd0) ? 3'd1 : d;
    endfunction

    function automatic logic [11:0] eff_per(input logic [11:0] f, input logic [2:0] d);
        logic [11:0] m;
        logic [11:0] floor_pulse;
        floor_pulse = {8'd0, d, 1'b0} + 12'd2;
        m = f;
        if (m < floor_pulse)
            m = floor_pulse;
        if (m < 12'(CLK_PER_PERIOD_MIN))
            m = 12'(CLK_PER_PERIOD_MIN);
        return m;
    endfunction

    // Bit k set when envelope state k+1 has a non-zero length.
    function automatic logic [3:0] nz_of(input logic [5:0] rl, input logic [7:0] onl,
                                         input logic [9:0] offl);
        return {offl != 10'd0, rl != 6'd0, onl != 8'd0, rl != 6'd0};
    endfunction

    // First non-empty state at or after index start; bit 3 flags a wrap past OFF.
    function automatic logic [3:0] first_from(input logic [1:0] start, input logic [3:0] nz);
        logic [3:0] r;
        r = {1'b1, ON};
        if (start == 2'd0 && nz[0])
            r = {1'b0, RAMP_UP};
        else if (start <= 2'd1 && nz[1])
            r = {1'b0, ON};
        else if (start <= 2'd2 && nz[2])
            r = {1'b0, RAMP_DN};
        else if (nz[3])
            r = {1'b0, OFF};
        return r;
    endfunction

    state_t      r_state, w_state_n;
    logic [11:0] r_pc, w_pc_n;
    logic [9:0]  r_cnt, w_cnt_n;
    logic [9:0]  r_acc, w_acc_n;

    logic [11:0] r_freq;
    logic [5:0]  r_amp, r_ramp;
    logic [9:0]  r_rf, r_off;
    logic [7:0]  r_on;
    logic [2:0]  r_pdur;
    logic [31:0] r_e1, r_e2;

    logic        w_new_cycle, w_start, w_in_pulse;
    logic [3:0]  w_pick;
    logic [10:0] w_sum;
    logic [2:0]  w_pd_cur, w_pd_sel;
    logic [11:0] w_per_cur;
    logic [9:0]  w_len_cur, w_amp16, w_rf_sel;
    logic [3:0]  w_nz_cur, w_nz_in;
    logic [31:0] w_e1_sel, w_e2_sel, w_up_n, w_dn_n;
    logic [5:0]  w_dac_n;
    logic        w_act_n;

    assign w_pd_cur   = eff_pd(r_pdur);
    assign w_per_cur  = eff_per(r_freq, w_pd_cur);
    assign w_nz_cur   = nz_of(r_ramp, r_on, r_off);
    assign w_nz_in    = nz_of(ramp, on_time, off_time);
    assign w_in_pulse = (r_state inside {RAMP_UP, ON, RAMP_DN}) &&
                        (r_pc < {8'd0, w_pd_cur, 1'b0});

    always_comb begin
        w_len_cur = 10'd0;
        case (r_state)
            RAMP_UP, RAMP_DN: w_len_cur = {4'd0, r_ramp};
            ON:               w_len_cur = {2'd0, r_on};
            OFF:              w_len_cur = r_off;
            default:          w_len_cur = 10'd0;
        endcase
    end

    always_comb begin
        w_state_n   = r_state;
        w_pc_n      = r_pc;
        w_cnt_n     = r_cnt;
        w_acc_n     = r_acc;
        w_new_cycle = 1'b0;
        w_start     = 1'b0;
        w_pick      = 4'd0;
        w_sum       = 11'd0;
        w_amp16     = 10'd0;
        w_rf_sel    = 10'd0;
        if (r_state == IDLE) begin
            w_new_cycle = enable;
        end else if (!enable && !w_in_pulse) begin
            w_state_n = IDLE;
            w_pc_n    = 12'd0;
            w_cnt_n   = 10'd0;
            w_acc_n   = 10'd0;
        end else if (r_pc == w_per_cur - 12'd1) begin
            w_pc_n  = 12'd0;
            w_start = 1'b1;
            // A zero length here only happens in the all-zero fallback: hold ON.
            if (w_len_cur != 10'd0 && r_cnt == w_len_cur) begin
                w_pick = first_from(r_state[1:0], w_nz_cur);
                if (r_state == OFF || w_pick[3]) begin
                    w_new_cycle = 1'b1;
                end else begin
                    w_state_n = state_t'(w_pick[2:0]);
                    w_cnt_n   = 10'd1;
                end
            end else begin
                w_cnt_n = r_cnt + 10'd1;
            end
        end else begin
            w_pc_n = r_pc + 12'd1;
        end

        if (w_new_cycle) begin
            w_start   = 1'b1;
            w_pc_n    = 12'd0;
            w_cnt_n   = 10'd1;
            w_pick    = first_from(2'd0, w_nz_in);
            w_state_n = w_pick[3] ? ON : state_t'(w_pick[2:0]);
        end

        w_amp16  = 10'(w_new_cycle ? amplitude : r_amp) << AMP_FRAC;
        w_rf_sel = w_new_cycle ? ramp_factor : r_rf;
        if (w_start) begin
            case (w_state_n)
                RAMP_UP: begin
                    w_sum   = {1'b0, (w_new_cycle ? 10'd0 : r_acc)} + {1'b0, w_rf_sel};
                    w_acc_n = (w_sum > {1'b0, w_amp16}) ? w_amp16 : w_sum[9:0];
                end
                ON:      w_acc_n = w_amp16;
                RAMP_DN: w_acc_n = (r_acc >= w_rf_sel) ? (r_acc - w_rf_sel) : 10'd0;
                default: w_acc_n = r_acc;
            endcase
        end
    end

    // Pulse shape is derived from the next tick so the outputs land registered.
    assign w_pd_sel = eff_pd(w_new_cycle ? phase_dur : r_pdur);
    assign w_e1_sel = w_new_cycle ? electrode1 : r_e1;
    assign w_e2_sel = w_new_cycle ? electrode2 : r_e2;

    always_comb begin
        w_up_n  = 32'd0;
        w_dn_n  = 32'd0;
        w_act_n = 1'b0;
        w_dac_n = 6'd0;
        if (w_state_n inside {RAMP_UP, ON, RAMP_DN}) begin
            if (w_pc_n < {9'd0, w_pd_sel}) begin
                w_up_n  = w_e1_sel;
                w_dn_n  = w_e2_sel;
                w_act_n = 1'b1;
            end else if (w_pc_n == {9'd0, w_pd_sel}) begin
                w_act_n = 1'b1;
            end else if (w_pc_n <= {8'd0, w_pd_sel, 1'b0}) begin
                w_up_n  = w_e2_sel;
                w_dn_n  = w_e1_sel;
                w_act_n = 1'b1;
            end
            if (w_act_n)
                w_dac_n = w_acc_n[AMP_FRAC +: 6];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_pc          <= 12'd0;
            r_cnt         <= 10'd0;
            r_acc         <= 10'd0;
            r_freq        <= 12'd0;
            r_amp         <= 6'd0;
            r_ramp        <= 6'd0;
            r_rf          <= 10'd0;
            r_on          <= 8'd0;
            r_off         <= 10'd0;
            r_pdur        <= 3'd0;
            r_e1          <= 32'd0;
            r_e2          <= 32'd0;
            up_switches   <= 32'd0;
            down_switches <= 32'd0;
            dac           <= 6'd0;
            pulse_active  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_pc    <= w_pc_n;
            r_cnt   <= w_cnt_n;
            r_acc   <= w_acc_n;
            if (w_new_cycle) begin
                r_freq <= freq;
                r_amp  <= amplitude;
                r_ramp <= ramp;
                r_rf   <= ramp_factor;
                r_on   <= on_time;
                r_off  <= off_time;
                r_pdur <= phase_dur;
                r_e1   <= electrode1;
                r_e2   <= electrode2;
            end
            up_switches   <= w_up_n;
            down_switches <= w_dn_n;
            dac           <= w_dac_n;
            pulse_active  <= w_act_n;
        end
    end

    assign state = r_state;

endmodule

`default_nettype wire
